dpll_loop_ctrl: RTL and testbench
=================================

# dpll_loop_ctrl

Loop controller for the digital PLL. It sits between the phase detector and the DCO. It integrates the detector's `up`/`dn` pulses over fixed update windows and turns each window's net phase error into a gain-scaled correction of the DCO tuning word. It also sequences the loop through acquire, track and lock, and reports lock status.

## Interface
Parameters:
- `W_CTRL`, 12, DCO tuning word width
- `W_ERR`, 8, signed window-error width; `WIN_LEN` must be ≤ 2^(W_ERR-1)-1
- `WIN_LEN`, 16, master cycles per update window
- `CTRL_INIT`, 12'h800, tuning word after reset or disable
- `ACQ_SHIFT`, 0, right-shift applied to error in ACQUIRE
- `TRK_SHIFT`, 2, right-shift applied to error in TRACK and LOCKED
- `LOCK_TOL`, 1, a window is "quiet" when |err| ≤ LOCK_TOL
- `LOCK_WINS`, 4, consecutive quiet windows in TRACK needed to declare lock

Ports:
- `master` in 1 — the single clock, rising edge
- `rst` in 1 — synchronous, active-high reset
- `en` in 1 — loop enable
- `up` in 1 — detector up, synchronous to `master`
- `dn` in 1 — detector down, synchronous to `master`
- `dco_word` out W_CTRL — DCO tuning word
- `upd` out 1 — one-cycle pulse when `dco_word` is updated
- `locked` out 1 — lock indicator
- `state` out 2 — FSM state: IDLE=0, ACQUIRE=1, TRACK=2, LOCKED=3
- `fault` out 1 — sticky flag, set when the tuning word saturates

## Operation
- **Reset** (`rst`=1 at an edge) forces: `dco_word`=CTRL_INIT, `state`=IDLE, `locked`=0, `upd`=0, `fault`=0; window counter, error and quiet count cleared.
- **IDLE**
  - Outputs hold their reset values.
  - A cycle with `en`=1 moves to ACQUIRE. The window starts on the first ACQUIRE cycle.
- **Per-cycle error accumulation** in ACQUIRE, TRACK and LOCKED:
  - `up & ~dn` → err += 1
  - `dn & ~up` → err -= 1
  - both or neither → no change
- **Window end** (window counter = WIN_LEN-1; the final cycle's contribution is included):
  - delta = err >>> shift, arithmetic; shift is selected by the state the window was measured in.
  - `dco_word` = clamp(`dco_word` + delta, 0, 2^W_CTRL-1). Any clamp sets `fault`.
  - err and window counter clear; `upd`=1.
- **ACQUIRE**: 2 consecutive quiet windows → TRACK.
- **TRACK**
  - Quiet window: quiet count +1. Non-quiet window: quiet count clears.
  - Quiet count reaching LOCK_WINS → LOCKED.
- **LOCKED**
  - |err| ≥ WIN_LEN/2 → ACQUIRE.
  - Otherwise |err| > 4·LOCK_TOL → TRACK.
  - Otherwise stay.
  - Any exit clears `locked` and the quiet count.
- **`en`=0** in any non-IDLE state: IDLE next edge. The partial window is discarded (no update, no `upd`), `dco_word`=CTRL_INIT, `fault` cleared.
- **`rst` and `en` together**: `rst` wins.

## Timing
- All outputs are registered.
- `dco_word`, `upd`, `state` and `locked` change on the same edge, the one ending the window's last cycle.
- `upd` is high for exactly 1 cycle per window. The minimum `upd` spacing is WIN_LEN cycles.
- Latency from a window's last detector sample to the new `dco_word` is 1 edge.
- `locked` rises together with the `upd` of the window that reached LOCK_WINS, and falls with the `upd` of the window that caused the exit.

## Configuration
- Macro `DPLL_HOLDOVER_EN`.
- **Defined**: adds input `hold` (1 bit).
  - While `hold`=1 in TRACK or LOCKED: windows are still measured and cleared, but `dco_word`, `state`, the quiet count and `fault` are frozen, and `upd` is suppressed.
  - `hold` is ignored in IDLE and ACQUIRE.
- **Undefined**: there is no `hold` port, and behaviour is identical to `hold`=0.

## Structure
- Shared package `dpll_pkg`: state codes (IDLE/ACQUIRE/TRACK/LOCKED) and the width-clamp helper function.
- One sub-module, `dpll_err_window`: window counter plus signed error accumulator. It outputs `win_end` and the final err.
- The FSM, gain shift and tuning-word clamp stay in `dpll_loop_ctrl`.

## Test plan
All scenarios use default parameters.
- **Reset**: `rst`=1 for 3 cycles → `dco_word`=0x800, `state`=0, `locked`=0, `upd`=0, `fault`=0.
- **Acquire step**: `en`=1, `up`=1 held → 16 cycles after entering ACQUIRE, `dco_word`=0x810, `upd` high 1 cycle, `state`=1.
- **Lock sequence**: `en`=1, `up`=`dn`=0 →
  - TRACK after window 2;
  - LOCKED with `locked`=1 at the `upd` of window 6;
  - `dco_word` stays 0x800.
- **Lock loss**: from LOCKED, `dn`=1 for 16 cycles → err=-16, delta=-4 → `dco_word`=0x7FC, `state`=ACQUIRE, `locked`=0.
- **Saturation**: CTRL_INIT=0xFF8, `up`=1 held → `dco_word`=0xFFF after the second window, `fault`=1.
- **Disable mid-window**: after 0x810, drop `en` at window cycle 7 → next edge `state`=IDLE, `dco_word`=0x800, no `upd`. With `DPLL_HOLDOVER_EN`, `hold`=1 in LOCKED plus `dn`=1 → `dco_word` unchanged and no `upd`.

Source files
------------

// File: rtl/dpll_pkg.sv
// Shared definitions for the DPLL loop controller: FSM state codes and the
// unsigned width-clamp helper used on the DCO tuning word.
package dpll_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StAcquire = 2'd1,
        StTrack   = 2'd2,
        StLocked  = 2'd3
    } dpll_state_e;

    // Clamp a signed value into the unsigned range [0, 2^width-1].
    function automatic logic signed [31:0] clamp_uwidth(input logic signed [31:0] val,
                                                        input int unsigned        width);
        logic signed [31:0] max_val;
        max_val = (32'sd1 <<< width) - 32'sd1;
        if (val < 32'sd0) begin
            return 32'sd0;
        end else if (val > max_val) begin
            return max_val;
        end
        return val;
    endfunction

endpackage

// File: rtl/dpll_err_window.sv
// Update-window counter and signed phase-error accumulator for the DPLL loop.
// err_o includes the current cycle's detector contribution, so at win_end_o it
// is the complete window error.
module dpll_err_window #(
    parameter int unsigned W_ERR   = 8,
    parameter int unsigned WIN_LEN = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    run_i,
    input  logic                    up_i,
    input  logic                    dn_i,
    output logic                    win_end_o,
    output logic signed [W_ERR-1:0] err_o
);

    localparam int unsigned W_CNT = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;

    logic [W_CNT-1:0]        cnt_q, cnt_d;
    logic signed [W_ERR-1:0] err_q, err_d, err_sum;

    // Error including this cycle, window-end detect and next counter/accumulator state.
    always_comb begin
        err_sum = err_q;
        if (up_i && !dn_i) begin
            err_sum = err_q + W_ERR'(1);
        end else if (dn_i && !up_i) begin
            err_sum = err_q - W_ERR'(1);
        end

        win_end_o = run_i && (cnt_q == W_CNT'(WIN_LEN - 1));
        err_o     = err_sum;

        if (!run_i || win_end_o) begin
            cnt_d = '0;
            err_d = '0;
        end else begin
            cnt_d = cnt_q + W_CNT'(1);
            err_d = err_sum;
        end
    end

    // Counter and accumulator registers, synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            err_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

endmodule

// File: rtl/dpll_loop_ctrl.sv
// DPLL loop controller: integrates detector up/dn over fixed windows, applies a
// state-dependent gain shift to the window error, updates the clamped DCO
// tuning word and sequences IDLE -> ACQUIRE -> TRACK -> LOCKED.
// Optional macro DPLL_HOLDOVER_EN adds a 'hold' input that freezes the loop
// in TRACK/LOCKED while windows keep being measured.
module dpll_loop_ctrl
    import dpll_pkg::*;
#(
    parameter int unsigned       W_CTRL    = 12,
    parameter int unsigned       W_ERR     = 8,
    parameter int unsigned       WIN_LEN   = 16,
    parameter logic [W_CTRL-1:0] CTRL_INIT = 12'h800,
    parameter int unsigned       ACQ_SHIFT = 0,
    parameter int unsigned       TRK_SHIFT = 2,
    parameter int unsigned       LOCK_TOL  = 1,
    parameter int unsigned       LOCK_WINS = 4
) (
    input  logic              master,
    input  logic              rst,
    input  logic              en,
    input  logic              up,
    input  logic              dn,
`ifdef DPLL_HOLDOVER_EN
    input  logic              hold,
`endif
    output logic [W_CTRL-1:0] dco_word,
    output logic              upd,
    output logic              locked,
    output logic [1:0]        state,
    output logic              fault
);

    localparam int unsigned ACQ_WINS = 2;
    localparam int unsigned Q_MAX    = (LOCK_WINS > ACQ_WINS) ? LOCK_WINS : ACQ_WINS;
    localparam int unsigned W_Q      = $clog2(Q_MAX + 1);

    dpll_state_e        state_q, state_d;
    logic [W_CTRL-1:0]  dco_q, dco_d;
    logic [W_Q-1:0]     quiet_q, quiet_d;
    logic               fault_q, fault_d;
    logic               upd_q, upd_d;
    logic               locked_q, locked_d;

    logic                    run;
    logic                    win_end;
    logic signed [W_ERR-1:0] err_fin;
    logic signed [W_ERR-1:0] delta;
    logic [W_ERR-1:0]        abs_err;
    logic                    quiet;
    logic signed [31:0]      sum_ext;
    logic signed [31:0]      clamped;
    logic                    sat;
    logic                    hold_eff;
    logic                    freeze;

`ifdef DPLL_HOLDOVER_EN
    assign hold_eff = hold;
`else
    assign hold_eff = 1'b0;
`endif

    assign run = en && (state_q != StIdle);

    dpll_err_window #(
        .W_ERR   (W_ERR),
        .WIN_LEN (WIN_LEN)
    ) u_err_window (
        .clk_i     (master),
        .rst_i     (rst),
        .run_i     (run),
        .up_i      (up),
        .dn_i      (dn),
        .win_end_o (win_end),
        .err_o     (err_fin)
    );

    // Gain shift, magnitude, quiet test and saturating tuning-word sum.
    always_comb begin
        freeze  = hold_eff && ((state_q == StTrack) || (state_q == StLocked));
        delta   = (state_q == StAcquire) ? (err_fin >>> ACQ_SHIFT) : (err_fin >>> TRK_SHIFT);
        abs_err = err_fin[W_ERR-1] ? W_ERR'(-err_fin) : W_ERR'(err_fin);
        quiet   = (abs_err <= W_ERR'(LOCK_TOL));
        sum_ext = signed'({{(32 - W_CTRL){1'b0}}, dco_q})
                + signed'({{(32 - W_ERR){delta[W_ERR-1]}}, delta});
        clamped = clamp_uwidth(sum_ext, W_CTRL);
        sat     = (clamped != sum_ext);
    end

    // Next-state logic for the FSM and all registered outputs.
    always_comb begin
        state_d  = state_q;
        dco_d    = dco_q;
        quiet_d  = quiet_q;
        fault_d  = fault_q;
        locked_d = locked_q;
        upd_d    = 1'b0;

        if (state_q == StIdle) begin
            if (en) begin
                state_d = StAcquire;
            end
        end else if (!en) begin
            // Abandon the partial window and return to the power-on tuning word.
            state_d  = StIdle;
            dco_d    = CTRL_INIT;
            quiet_d  = '0;
            fault_d  = 1'b0;
            locked_d = 1'b0;
        end else if (win_end && !freeze) begin
            upd_d = 1'b1;
            dco_d = clamped[W_CTRL-1:0];
            if (sat) begin
                fault_d = 1'b1;
            end
            unique case (state_q)
                StAcquire: begin
                    if (!quiet) begin
                        quiet_d = '0;
                    end else if (int'(quiet_q) + 1 >= int'(ACQ_WINS)) begin
                        state_d = StTrack;
                        quiet_d = '0;
                    end else begin
                        quiet_d = quiet_q + W_Q'(1);
                    end
                end
                StTrack: begin
                    if (!quiet) begin
                        quiet_d = '0;
                    end else if (int'(quiet_q) + 1 >= int'(LOCK_WINS)) begin
                        state_d  = StLocked;
                        locked_d = 1'b1;
                        quiet_d  = '0;
                    end else begin
                        quiet_d = quiet_q + W_Q'(1);
                    end
                end
                StLocked: begin
                    if (abs_err >= W_ERR'(WIN_LEN / 2)) begin
                        state_d  = StAcquire;
                        locked_d = 1'b0;
                        quiet_d  = '0;
                    end else if (abs_err > W_ERR'(4 * LOCK_TOL)) begin
                        state_d  = StTrack;
                        locked_d = 1'b0;
                        quiet_d  = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // State and output registers, synchronous active-high reset.
    always_ff @(posedge master) begin
        if (rst) begin
            state_q  <= StIdle;
            dco_q    <= CTRL_INIT;
            quiet_q  <= '0;
            fault_q  <= 1'b0;
            upd_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            dco_q    <= dco_d;
            quiet_q  <= quiet_d;
            fault_q  <= fault_d;
            upd_q    <= upd_d;
            locked_q <= locked_d;
        end
    end

    assign dco_word = dco_q;
    assign upd      = upd_q;
    assign locked   = locked_q;
    assign state    = state_q;
    assign fault    = fault_q;

endmodule

// File: tb/tb_dpll_loop_ctrl.sv
// Directed bench for dpll_loop_ctrl. A second instance with CTRL_INIT=0xFF8
// shares the stimulus and is used for the saturation checks.
module tb_dpll_loop_ctrl;

    logic        master = 1'b0;
    logic        rst    = 1'b1;
    logic        en     = 1'b0;
    logic        up     = 1'b0;
    logic        dn     = 1'b0;
    logic        hold   = 1'b0;

    logic [11:0] dco_word,  s_dco_word;
    logic        upd,       s_upd;
    logic        locked,    s_locked;
    logic [1:0]  state,     s_state;
    logic        fault,     s_fault;

    int errors = 0;
    int checks = 0;

    always #5 master = ~master;

    dpll_loop_ctrl u_dut (
        .master   (master),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .dn       (dn),
`ifdef DPLL_HOLDOVER_EN
        .hold     (hold),
`endif
        .dco_word (dco_word),
        .upd      (upd),
        .locked   (locked),
        .state    (state),
        .fault    (fault)
    );

    dpll_loop_ctrl #(
        .CTRL_INIT (12'hFF8)
    ) u_dut_sat (
        .master   (master),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .dn       (dn),
`ifdef DPLL_HOLDOVER_EN
        .hold     (hold),
`endif
        .dco_word (s_dco_word),
        .upd      (s_upd),
        .locked   (s_locked),
        .state    (s_state),
        .fault    (s_fault)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge master);
        #1;
    endtask

    int exp_state [6] = '{1, 2, 2, 2, 2, 3};
    int exp_lock  [6] = '{0, 0, 0, 0, 0, 1};

    initial begin
        // Reset
        tick(3);
        check("rst_dco",    dco_word, 12'h800);
        check("rst_state",  state,    2'd0);
        check("rst_locked", locked,   1'b0);
        check("rst_upd",    upd,      1'b0);
        check("rst_fault",  fault,    1'b0);

        // rst wins over en
        en = 1'b1;
        tick(1);
        check("rst_en_state", state, 2'd0);

        // Acquire step
        rst = 1'b0;
        up  = 1'b1;
        tick(1);
        check("acq_enter_state", state, 2'd1);
        tick(15);
        check("acq_pre_upd", upd,      1'b0);
        check("acq_pre_dco", dco_word, 12'h800);
        tick(1);
        check("acq_dco",   dco_word, 12'h810);
        check("acq_upd",   upd,      1'b1);
        check("acq_state", state,    2'd1);
        check("sat1_dco",   s_dco_word, 12'hFFF);
        check("sat1_fault", s_fault,    1'b1);
        tick(1);
        check("acq_upd_fall", upd, 1'b0);

        // Disable at window cycle 7
        tick(6);
        en = 1'b0;
        tick(1);
        check("dis_state", state,    2'd0);
        check("dis_dco",   dco_word, 12'h800);
        check("dis_upd",   upd,      1'b0);
        check("dis_fault_sat", s_fault,    1'b0);
        check("dis_dco_sat",   s_dco_word, 12'hFF8);

        // Lock sequence with a silent detector
        up = 1'b0;
        en = 1'b1;
        tick(1);
        for (int w = 0; w < 6; w++) begin
            tick(16);
            check($sformatf("lock_w%0d_state", w + 1), state, exp_state[w]);
            check($sformatf("lock_w%0d_locked", w + 1), locked, exp_lock[w]);
            check($sformatf("lock_w%0d_upd", w + 1), upd, 1'b1);
            check($sformatf("lock_w%0d_dco", w + 1), dco_word, 12'h800);
        end

        // Lock loss: 16 dn cycles -> err=-16, delta=-4
        dn = 1'b1;
        tick(15);
        check("loss_pre_locked", locked, 1'b1);
        tick(1);
        check("loss_dco",    dco_word, 12'h7FC);
        check("loss_state",  state,    2'd1);
        check("loss_locked", locked,   1'b0);
        check("loss_upd",    upd,      1'b1);
        dn = 1'b0;

        // Saturation over two full windows with up held
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        up  = 1'b1;
        tick(1);
        tick(32);
        check("sat2_dco",   s_dco_word, 12'hFFF);
        check("sat2_fault", s_fault,    1'b1);
        check("nosat_dco",  dco_word,   12'h820);
        check("nosat_fault", fault,     1'b0);
        up = 1'b0;

`ifdef DPLL_HOLDOVER_EN
        // Holdover in LOCKED: dn activity must not move the tuning word
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
        tick(16 * 6);
        check("hold_pre_state", state, 2'd3);
        hold = 1'b1;
        dn   = 1'b1;
        tick(15);
        check("hold_upd_mid", upd, 1'b0);
        tick(1);
        check("hold_dco",   dco_word, 12'h800);
        check("hold_upd",   upd,      1'b0);
        check("hold_state", state,    2'd3);
        hold = 1'b0;
        dn   = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
